// File: rtl/scad_step_if.sv
// Bus bundle between the microsequencer and the SCAD step-count engine.
// The master modport is the microsequencer side, the slave modport is the engine.
interface scad_step_if #(
    parameter int WIDTH = 10
);
    logic [2:0]       fun;
    logic [1:0]       asel;
    logic [1:0]       bsel;
    logic [WIDTH-1:0] snum;
    logic [WIDTH-1:0] dpa;
    logic [WIDTH-1:0] dpb;
    logic             loadFE;
    logic             loadSC;
    logic             start;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] scad;
    logic [WIDTH-1:0] fe;
    logic [WIDTH-1:0] sc;
    logic             feSIGN;
    logic             scSIGN;
    logic [3:0]       dispSCAD;
    logic             scadCY;

    modport master (
        output fun, asel, bsel, snum, dpa, dpb, loadFE, loadSC, start, count,
        input  busy, done, scad, fe, sc, feSIGN, scSIGN, dispSCAD, scadCY
    );

    modport slave (
        input  fun, asel, bsel, snum, dpa, dpb, loadFE, loadSC, start, count,
        output busy, done, scad, fe, sc, feSIGN, scSIGN, dispSCAD, scadCY
    );
endinterface

// File: rtl/scad_step_engine.sv
// SCAD step-count engine: A/B operand muxes, 8-function SCAD ALU, FE and SC
// registers, and a loop sequencer that counts SC down until it goes negative.
// Optional feature: define SCAD_CARRY_EN to produce the ALU carry/borrow on
// scadCY; without it scadCY is tied low and no carry logic exists.
module scad_step_engine #(
    parameter int WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clken,
    scad_step_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] fe_q, fe_d;
    logic [WIDTH-1:0] sc_q, sc_d;
    logic [WIDTH-1:0] a_op, b_op, scad_w;

    // Operand selection for the A and B ALU inputs
    always_comb begin
        a_op = '0;
        b_op = '0;
        unique case (bus.asel)
            2'd0: a_op = sc_q;
            2'd1: a_op = bus.snum;
            2'd2: a_op = bus.dpa;
            default: a_op = fe_q;
        endcase
        unique case (bus.bsel)
            2'd0: b_op = fe_q;
            2'd1: b_op = bus.dpb;
            2'd2: b_op = bus.snum;
            default: b_op = sc_q;
        endcase
    end

    // SCAD ALU, all results wrap modulo 2**WIDTH
    always_comb begin
        scad_w = '0;
        unique case (bus.fun)
            3'd0: scad_w = a_op + a_op;
            3'd1: scad_w = a_op | b_op;
            3'd2: scad_w = a_op - b_op - ONE;
            3'd3: scad_w = a_op - b_op;
            3'd4: scad_w = a_op + b_op;
            3'd5: scad_w = a_op & b_op;
            3'd6: scad_w = a_op - ONE;
            default: scad_w = a_op;
        endcase
    end

`ifdef SCAD_CARRY_EN
    logic [WIDTH:0] sum_ab;
    logic           cy_w;

    assign sum_ab = {1'b0, a_op} + {1'b0, b_op};

    // Carry out of the MSB for adds, unsigned borrow for subtracts
    always_comb begin
        cy_w = 1'b0;
        unique case (bus.fun)
            3'd0: cy_w = a_op[WIDTH-1];
            3'd2: cy_w = (a_op <= b_op);
            3'd3: cy_w = (a_op < b_op);
            3'd4: cy_w = sum_ab[WIDTH];
            3'd6: cy_w = (a_op == '0);
            default: cy_w = 1'b0;
        endcase
    end

    assign bus.scadCY = cy_w;
`else
    assign bus.scadCY = 1'b0;
`endif

    assign bus.scad     = scad_w;
    assign bus.dispSCAD = scad_w[WIDTH-1] ? 4'b0010 : 4'b0000;
    assign bus.fe       = fe_q;
    assign bus.sc       = sc_q;
    assign bus.feSIGN   = fe_q[WIDTH-1];
    assign bus.scSIGN   = sc_q[WIDTH-1];

    // Next values for FE and SC; start outranks loadSC, RUN owns SC
    always_comb begin
        fe_d = fe_q;
        sc_d = sc_q;
        if (clken && bus.loadFE) begin
            fe_d = scad_w;
        end
        unique case (state_q)
            S_IDLE: begin
                if (clken && bus.start) begin
                    sc_d = bus.count;
                end else if (clken && bus.loadSC) begin
                    sc_d = scad_w;
                end
            end
            S_RUN: begin
                if (clken) begin
                    sc_d = sc_q - ONE;
                end
            end
            default: begin
                if (clken && bus.loadSC) begin
                    sc_d = scad_w;
                end
            end
        endcase
    end

    // Sequencer next state; DONE always lasts one clock regardless of clken
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (clken && bus.start) begin
                    state_d = bus.count[WIDTH-1] ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (clken && (sc_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer status outputs decoded from the current state
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            S_RUN:   bus.busy = 1'b1;
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Register update; reset takes priority over clken
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            fe_q    <= '0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            fe_q    <= fe_d;
            sc_q    <= sc_d;
        end
    end
endmodule

// File: tb/tb_scad_step_engine.sv
// Directed bench for scad_step_engine at WIDTH=10: ALU vectors, loop
// sequencer timing, clock-enable gating and reset during a running loop.
module tb_scad_step_engine;
    localparam int W = 10;

    logic clk;
    logic rst;
    logic clken;
    int   n_checks;
    int   n_fail;

    scad_step_if #(.WIDTH(W)) bus ();

    scad_step_engine #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .clken (clken),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic       tgl_en   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [9:0] tgl_sc   [6] = '{10'd2, 10'd1, 10'd1, 10'd0, 10'd0, 10'o1777};
    logic       tgl_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       tgl_done [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'o%0o want 'o%0o", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string tag, input logic [2:0] f, input logic [1:0] a,
                           input logic [1:0] b, input logic [9:0] sn, input logic [9:0] da,
                           input logic [9:0] db, input logic [9:0] exp_scad,
                           input logic exp_cy);
        logic cy_want;
        bus.fun  = f;
        bus.asel = a;
        bus.bsel = b;
        bus.snum = sn;
        bus.dpa  = da;
        bus.dpb  = db;
        @(negedge clk);
        chk({tag, ".scad"}, bus.scad, exp_scad);
        chk({tag, ".disp"}, bus.dispSCAD, exp_scad[9] ? 4'b0010 : 4'b0000);
`ifdef SCAD_CARRY_EN
        cy_want = exp_cy;
`else
        cy_want = 1'b0;
`endif
        chk({tag, ".cy"}, bus.scadCY, cy_want);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        clken       = 1'b0;
        bus.fun     = 3'd7;
        bus.asel    = 2'd1;
        bus.bsel    = 2'd0;
        bus.snum    = 10'o77;
        bus.dpa     = '0;
        bus.dpb     = '0;
        bus.loadFE  = 1'b1;
        bus.loadSC  = 1'b1;
        bus.start   = 1'b1;
        bus.count   = 10'd3;

        // reset with clken low and loads requested
        tick();
        tick();
        chk("rst.fe", bus.fe, 0);
        chk("rst.sc", bus.sc, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);

        // load FE = 5 through the A path
        rst        = 1'b1;
        bus.loadSC = 1'b0;
        bus.start  = 1'b0;
        clken      = 1'b1;
        bus.snum   = 10'd5;
        tick();
        chk("ldfe.fe", bus.fe, 10'd5);
        chk("ldfe.sign", bus.feSIGN, 0);
        bus.loadFE = 1'b0;

        // ALU vectors with fe=5, sc=0
        alu_vec("add_snum_fe", 3'd4, 2'd1, 2'd0, 10'o12,   0, 0, 10'o17,   1'b0);
        alu_vec("dec_zero",    3'd6, 2'd1, 2'd0, 10'd0,    0, 0, 10'o1777, 1'b1);
        alu_vec("sub_neg",     3'd3, 2'd1, 2'd0, 10'd3,    0, 0, 10'o1776, 1'b1);
        alu_vec("subm1_neg",   3'd2, 2'd1, 2'd0, 10'd3,    0, 0, 10'o1775, 1'b1);
        alu_vec("subm1_zero",  3'd2, 2'd1, 2'd0, 10'd6,    0, 0, 10'd0,    1'b0);
        alu_vec("or",          3'd1, 2'd1, 2'd0, 10'o12,   0, 0, 10'o17,   1'b0);
        alu_vec("and",         3'd5, 2'd1, 2'd0, 10'o17,   0, 0, 10'd5,    1'b0);
        alu_vec("dbl_wrap",    3'd0, 2'd1, 2'd0, 10'o1400, 0, 0, 10'o1000, 1'b1);
        alu_vec("add_dp",      3'd4, 2'd2, 2'd1, 10'd0, 10'o1000, 10'o1000, 10'd0, 1'b1);
        alu_vec("pass_fe",     3'd7, 2'd3, 2'd0, 10'd0,    0, 0, 10'd5,    1'b0);
        alu_vec("sc_m_snum",   3'd3, 2'd0, 2'd2, 10'd1,    0, 0, 10'o1777, 1'b1);
        alu_vec("snum_p_sc",   3'd4, 2'd1, 2'd3, 10'd7,    0, 0, 10'd7,    1'b0);
        alu_vec("dec_msb",     3'd6, 2'd1, 2'd0, 10'o1000, 0, 0, 10'o777,  1'b0);

        // loop count=3; start and loadSC held during RUN must be ignored
        @(posedge clk);
        #1;
        bus.count = 10'd3;
        bus.start = 1'b1;
        tick();
        bus.count  = 10'd7;
        bus.loadSC = 1'b1;
        bus.fun    = 3'd7;
        bus.asel   = 2'd1;
        bus.snum   = 10'd100;
        for (int i = 0; i < 4; i++) begin
            chk("run3.busy", bus.busy, 1);
            chk("run3.sc", bus.sc, 3 - i);
            chk("run3.done", bus.done, 0);
            tick();
        end
        chk("run3.fin_done", bus.done, 1);
        chk("run3.fin_busy", bus.busy, 0);
        chk("run3.fin_sc", bus.sc, 10'o1777);
        chk("run3.fin_sign", bus.scSIGN, 1);
        tick();
        chk("done_ld.sc", bus.sc, 10'd100);
        chk("done_ld.done", bus.done, 0);
        chk("done_ld.busy", bus.busy, 0);
        bus.start  = 1'b0;
        bus.loadSC = 1'b0;
        tick();
        chk("idle_after.busy", bus.busy, 0);
        chk("idle_after.sc", bus.sc, 10'd100);

        // negative count goes straight to DONE
        bus.count = 10'o1000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("neg.busy", bus.busy, 0);
        chk("neg.done", bus.done, 1);
        chk("neg.sc", bus.sc, 10'o1000);
        tick();
        chk("neg.done2", bus.done, 0);
        chk("neg.busy2", bus.busy, 0);

        // count=2 with clken toggling
        bus.count = 10'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("tgl.sc0", bus.sc, 10'd2);
        chk("tgl.busy0", bus.busy, 1);
        for (int i = 0; i < 6; i++) begin
            clken = tgl_en[i];
            tick();
            chk("tgl.sc", bus.sc, tgl_sc[i]);
            chk("tgl.busy", bus.busy, tgl_busy[i]);
            chk("tgl.done", bus.done, tgl_done[i]);
        end
        clken = 1'b0;
        tick();
        chk("tgl.done_off", bus.done, 0);
        chk("tgl.busy_off", bus.busy, 0);

        // reset in the middle of a run
        clken     = 1'b1;
        bus.count = 10'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("mid.sc", bus.sc, 10'd4);
        chk("mid.busy", bus.busy, 1);
        rst = 1'b0;
        tick();
        chk("mid_rst.busy", bus.busy, 0);
        chk("mid_rst.done", bus.done, 0);
        chk("mid_rst.sc", bus.sc, 0);
        chk("mid_rst.fe", bus.fe, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst.done2", bus.done, 0);
        chk("mid_rst.busy2", bus.busy, 0);
        bus.count = 10'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("post.sc1", bus.sc, 10'd1);
        chk("post.busy", bus.busy, 1);
        tick();
        chk("post.sc0", bus.sc, 10'd0);
        tick();
        chk("post.sc_neg", bus.sc, 10'o1777);
        chk("post.done", bus.done, 1);
        chk("post.busy_end", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
